// File: rtl/aes_round_engine.sv
// Iterative AES encryption engine: one SubBytes/ShiftRows/MixColumns/AddRoundKey datapath
// reused for NUM_ROUNDS cycles, with round keys fetched from an external store by index.
`ifndef AES_BLOCK_SIZE
`define AES_BLOCK_SIZE 128
`endif

module aes_round_engine #(
    parameter int unsigned NUM_ROUNDS = 10,
    parameter int unsigned KEY_IDX_W  = 4
) (
    input  logic                       Clk,
    input  logic                       Rst_n,
    input  logic                       Input_valid,
    output logic                       Input_ready,
    input  logic [`AES_BLOCK_SIZE-1:0] Input_block,
    output logic [KEY_IDX_W-1:0]       Key_idx,
    input  logic [`AES_BLOCK_SIZE-1:0] Round_key,
    output logic                       Output_valid,
    input  logic                       Output_ready,
    output logic [`AES_BLOCK_SIZE-1:0] Output_block,
    output logic                       Busy
);

    if (!(NUM_ROUNDS == 10 || NUM_ROUNDS == 12 || NUM_ROUNDS == 14)) begin : g_bad_rounds
        $error("aes_round_engine: NUM_ROUNDS must be 10, 12 or 14");
    end
    if ((2 ** KEY_IDX_W) <= NUM_ROUNDS) begin : g_bad_idx_w
        $error("aes_round_engine: KEY_IDX_W too narrow for NUM_ROUNDS");
    end

    typedef enum logic [1:0] {StIdle, StRound, StDone} state_e;

    state_e                       state_q;
    logic [KEY_IDX_W-1:0]         round_q;
    logic [`AES_BLOCK_SIZE-1:0]   data_q;
    logic                         out_valid_q;
    logic                         busy_q;
    logic                         last_round;
    logic [`AES_BLOCK_SIZE-1:0]   shifted;
    logic [`AES_BLOCK_SIZE-1:0]   mixed;
    logic [`AES_BLOCK_SIZE-1:0]   round_out;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (0 maps to 0), followed by the affine transform.
    function automatic logic [7:0] sub_byte(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] base;
        inv  = 8'h01;
        base = x;
        for (int i = 1; i < 8; i++) begin
            base = gf_mul(base, base);
            inv  = gf_mul(inv, base);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    assign last_round = (round_q == KEY_IDX_W'(NUM_ROUNDS));

    // Byte i is row i%4, column i/4; row r rotates left by r columns.
    always_comb begin
        shifted = '0;
        mixed   = '0;
        for (int i = 0; i < 16; i++) begin
            shifted[127-8*i -: 8] =
                sub_byte(data_q[127-8*(4*(((i/4)+(i%4))%4)+(i%4)) -: 8]);
        end
        for (int c = 0; c < 4; c++) begin
            mixed[127-32*c -: 32] = mix_column(shifted[127-32*c -: 32]);
        end
        round_out = (last_round ? shifted : mixed) ^ Round_key;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= StIdle;
            round_q     <= '0;
            data_q      <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (Input_valid && Input_ready) begin
                        data_q      <= Input_block ^ Round_key;
                        round_q     <= KEY_IDX_W'(1);
                        state_q     <= StRound;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b1;
                    end else if (state_q == StDone && Output_ready) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                    end
                end
                StRound: begin
                    data_q <= round_out;
                    if (last_round) begin
                        // Counter returns to 0 so Key_idx reads 0 outside ROUND.
                        round_q     <= '0;
                        state_q     <= StDone;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end else begin
                        round_q <= round_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign Input_ready  = (state_q == StIdle) || ((state_q == StDone) && Output_ready);
    assign Key_idx      = round_q;
    assign Output_valid = out_valid_q;
    assign Output_block = data_q;
    assign Busy         = busy_q;

endmodule

// File: tb/tb_aes_round_engine.sv
// Bench for aes_round_engine: AES-128 instance checked every cycle against a queue-free
// timing model and a table-driven AES reference, plus a directed AES-256 instance.
module tb_aes_round_engine;

    localparam int NR = 10;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0] in_block, round_key, out_block;
    logic [3:0]   key_idx;
    logic         in_valid_b, in_ready_b, out_valid_b, out_ready_b, busy_b;
    logic [127:0] in_block_b, round_key_b, out_block_b;
    logic [3:0]   key_idx_b;

    int checks = 0;
    int errors = 0;

    logic [7:0]   exp_t [0:255];
    logic [7:0]   log_t [0:255];
    logic [7:0]   sbox_t[0:255];
    logic [127:0] rk_a  [0:14];
    logic [127:0] rk_b  [0:14];
    logic [127:0] garbage;

    always #5 clk = ~clk;

    aes_round_engine #(.NUM_ROUNDS(10), .KEY_IDX_W(4)) u_dut (
        .Clk(clk), .Rst_n(rst_n), .Input_valid(in_valid), .Input_ready(in_ready),
        .Input_block(in_block), .Key_idx(key_idx), .Round_key(round_key),
        .Output_valid(out_valid), .Output_ready(out_ready), .Output_block(out_block),
        .Busy(busy)
    );

    aes_round_engine #(.NUM_ROUNDS(14), .KEY_IDX_W(4)) u_dut256 (
        .Clk(clk), .Rst_n(rst_n), .Input_valid(in_valid_b), .Input_ready(in_ready_b),
        .Input_block(in_block_b), .Key_idx(key_idx_b), .Round_key(round_key_b),
        .Output_valid(out_valid_b), .Output_ready(out_ready_b), .Output_block(out_block_b),
        .Busy(busy_b)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        if (a == 0 || b == 0) return 8'h00;
        return exp_t[(int'(log_t[a]) + int'(log_t[b])) % 255];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    function automatic logic [127:0] rk(input int nr, input int r);
        return (nr == 10) ? rk_a[r] : rk_b[r];
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input int nr);
        logic [7:0]   s[16];
        logic [7:0]   t[16];
        logic [127:0] k;
        logic [127:0] res;
        k = rk(nr, 0);
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ k[127-8*i -: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox_t[s[4*(((i/4)+(i%4))%4)+(i%4)]];
            for (int c = 0; c < 4; c++) begin
                for (int w = 0; w < 4; w++) begin
                    if (r < nr)
                        s[4*c+w] = gmul(8'h02, t[4*c+w]) ^ gmul(8'h03, t[4*c+(w+1)%4])
                                 ^ t[4*c+(w+2)%4] ^ t[4*c+(w+3)%4];
                    else
                        s[4*c+w] = t[4*c+w];
                end
            end
            k = rk(nr, r);
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    task automatic build_tables();
        logic [7:0] e;
        logic [7:0] inv;
        e = 8'h01;
        for (int i = 0; i < 255; i++) begin
            exp_t[i] = e;
            log_t[e] = 8'(i);
            e = e ^ xt(e);
        end
        exp_t[255] = 8'h01;
        log_t[0]   = 8'h00;
        for (int x = 0; x < 256; x++) begin
            inv = (x == 0) ? 8'h00 : exp_t[(255 - int'(log_t[x])) % 255];
            sbox_t[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                      ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    task automatic expand(input logic [255:0] key, input int nr, input bit to_b);
        logic [31:0]  w[60];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        int           nk;
        nk = nr - 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            tmp = w[i-1];
            if (i % nk == 0) begin
                tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                tmp = sub_word(tmp);
            end
            w[i] = w[i-nk] ^ tmp;
        end
        for (int r = 0; r <= nr; r++) begin
            if (to_b) rk_b[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            else      rk_a[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
    endtask

    // Timing model: cd counts rounds still to run; holding means a result awaits Output_ready.
    int           cd = 0;
    logic         holding = 1'b0;
    logic [127:0] cur_ct, last_out = '0;
    logic         m_ready;
    int           exp_idx;

    assign m_ready = (cd == 0) && (!holding || out_ready);
    assign exp_idx = (cd > 0) ? (NR + 1 - cd) : 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cd       <= 0;
            holding  <= 1'b0;
            last_out <= '0;
        end else if (in_valid && m_ready) begin
            cd      <= NR;
            holding <= 1'b0;
            cur_ct  <= aes_enc(in_block, NR);
        end else if (cd > 0) begin
            cd <= cd - 1;
            if (cd == 1) begin
                holding  <= 1'b1;
                last_out <= cur_ct;
            end
        end else if (holding && out_ready) begin
            holding <= 1'b0;
        end
    end

    always @(posedge clk) garbage <= {$urandom, $urandom, $urandom, $urandom};

    // Correct key only when the DUT asks for the index the model expects and it can be used.
    always_comb begin
        round_key = garbage;
        if (key_idx == 4'(exp_idx) && (cd > 0 || in_valid)) round_key = rk_a[key_idx];
    end

    always_comb begin
        round_key_b = garbage;
        if (key_idx_b <= 4'd14) round_key_b = rk_b[key_idx_b];
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", {127'b0, in_ready}, {127'b0, m_ready});
            chk("out_valid", {127'b0, out_valid}, {127'b0, holding});
            chk("busy", {127'b0, busy}, {127'b0, cd > 0});
            chk("key_idx", {124'b0, key_idx}, 128'(exp_idx));
            if (cd == 0) chk("out_block", out_block, last_out);
        end
    end

    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    initial begin
        int           lat;
        int           max_idx;
        int           outs;
        int           idx;
        int           last_cyc;
        logic [127:0] blocks[5];
        logic         acc;

        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; in_block = '0;
        in_valid_b = 1'b0; out_ready_b = 1'b0; in_block_b = '0;
        build_tables();
        expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 10, 1'b0);
        expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 14, 1'b1);
        chk("model_rk10", rk_a[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
        chk("model_ct128", aes_enc(PT, 10), CT128);
        chk("model_ct256", aes_enc(PT, 14), CT256);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {127'b0, in_ready}, 128'd1);
        chk("rst_out_valid", {127'b0, out_valid}, 128'd0);
        chk("rst_out_block", out_block, 128'd0);
        chk("rst_busy", {127'b0, busy}, 128'd0);
        chk("rst_key_idx", {124'b0, key_idx}, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // AES-256 instance: FIPS vector, latency 15, Key_idx reaches 14.
        @(posedge clk); #1;
        in_valid_b = 1'b1; in_block_b = PT; out_ready_b = 1'b1;
        @(posedge clk); #1;
        in_valid_b = 1'b0;
        lat = 1; max_idx = 0;
        while (!out_valid_b && lat < 40) begin
            if (int'(key_idx_b) > max_idx) max_idx = int'(key_idx_b);
            @(posedge clk); #1;
            lat++;
        end
        chk("lat256", 128'(lat), 128'd15);
        chk("max_idx256", 128'(max_idx), 128'd14);
        chk("ct256", out_block_b, CT256);

        // AES-128 FIPS vector: latency 11 and Key_idx 1..10 through the rounds.
        @(posedge clk); #1;
        in_valid = 1'b1; in_block = PT; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_block = {$urandom, $urandom, $urandom, $urandom};
        lat = 1;
        while (!out_valid && lat < 40) begin
            chk("key_seq", {124'b0, key_idx}, 128'(lat));
            @(posedge clk); #1;
            lat++;
        end
        chk("lat128", 128'(lat), 128'd11);
        chk("ct128", out_block, CT128);

        // Backpressure: hold the result for 7 cycles while a new block is offered.
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; in_block = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        chk("bp_done", {127'b0, out_valid}, 128'd1);
        in_valid = 1'b1;
        repeat (7) begin
            in_block = {$urandom, $urandom, $urandom, $urandom};
            #1 chk("bp_in_ready", {127'b0, in_ready}, 128'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1; in_block = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_accept_busy", {127'b0, busy}, 128'd1);
        chk("bp_accept_idx", {124'b0, key_idx}, 128'd1);
        lat = 0;
        while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        @(posedge clk); #1;

        // Back-to-back stream: results every NR+1 cycles.
        blocks[0] = PT;
        for (int i = 1; i < 5; i++) blocks[i] = {$urandom, $urandom, $urandom, $urandom};
        idx = 0; outs = 0; last_cyc = -1;
        in_valid = 1'b1; in_block = blocks[0]; out_ready = 1'b1;
        for (int cyc = 0; cyc < 100 && outs < 4; cyc++) begin
            #1;
            acc = in_valid && in_ready;
            if (out_valid) begin
                if (last_cyc >= 0) chk("stream_gap", 128'(cyc - last_cyc), 128'(NR + 1));
                last_cyc = cyc;
                outs++;
            end
            @(posedge clk); #1;
            if (acc) idx++;
            in_block = blocks[idx];
            if (idx >= 4) in_valid = 1'b0;
        end
        chk("stream_outs", 128'(outs), 128'd4);
        repeat (3) @(posedge clk);
        #1;

        // Reset in round 5, then a fresh block.
        in_valid = 1'b1; in_block = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (key_idx != 4'd5 && lat < 20) begin @(posedge clk); #1; lat++; end
        chk("rst_round5", {124'b0, key_idx}, 128'd5);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_in_ready", {127'b0, in_ready}, 128'd1);
        chk("mid_out_valid", {127'b0, out_valid}, 128'd0);
        chk("mid_out_block", out_block, 128'd0);
        chk("mid_busy", {127'b0, busy}, 128'd0);
        chk("mid_key_idx", {124'b0, key_idx}, 128'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b1; in_block = PT;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        chk("post_rst_ct", out_block, CT128);

        // Random handshake traffic.
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            in_block  = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (NR + 3) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_round_engine.md
Name: aes_round_engine

Overview:
Iterative AES encryption core that reuses one registered round datapath (SubBytes, ShiftRows, MixColumns, AddRoundKey) over NUM_ROUNDS cycles. Round count is parametrised for AES-128/192/256. Plaintext enters and ciphertext leaves on valid/ready handshakes. Round keys are fetched from an external key-schedule store through an index/data port; the store is read combinationally in the same cycle.

Parameters:
NUM_ROUNDS, 10, number of full rounds; legal values 10, 12, 14 (AES-128/192/256); any other value is a elaboration error.
KEY_IDX_W, 4, width of Key_idx; must satisfy 2**KEY_IDX_W > NUM_ROUNDS.

Ports:
Clk  input  1  system clock, all state on rising edge.
Rst_n  input  1  asynchronous active-low reset.
Input_valid  input  1  plaintext block valid.
Input_ready  output  1  engine can accept a block this cycle.
Input_block  input  `AES_BLOCK_SIZE  plaintext block.
Key_idx  output  KEY_IDX_W  index of round key required this cycle.
Round_key  input  `AES_BLOCK_SIZE  round key for Key_idx, valid in the same cycle.
Output_valid  output  1  ciphertext block valid.
Output_ready  input  1  downstream accepts ciphertext.
Output_block  output  `AES_BLOCK_SIZE  ciphertext block.
Busy  output  1  high in ROUND state.

Behaviour:
- Reset (Rst_n low, asynchronous): state=IDLE, round counter=0, state register=0. Outputs: Input_ready=1, Output_valid=0, Output_block=0, Busy=0, Key_idx=0.
- The FSM has three states: IDLE, ROUND, DONE.
- IDLE:
  - Key_idx=0 and Input_ready=1.
  - On Input_valid: state register <= Input_block ^ Round_key (initial AddRoundKey), counter <= 1, go to ROUND.
- ROUND:
  - Key_idx=counter and Input_ready=0.
  - Each cycle, state register <= round(state register, Round_key).
  - MixColumns is bypassed when counter==NUM_ROUNDS (last round).
  - When counter==NUM_ROUNDS, go to DONE; otherwise counter <= counter+1.
- DONE:
  - Output_valid=1 and Output_block=state register, held stable until Output_ready.
  - Key_idx=0 and Input_ready=Output_ready.
  - On Output_ready with no Input_valid: go to IDLE.
  - On Output_ready with Input_valid in the same cycle: load the new block (initial AddRoundKey as in IDLE), counter <= 1, go to ROUND. There is no idle bubble.
  - Input_valid without Output_ready is ignored; the block is not consumed.
- Latency: the block accepted at edge T has Output_valid high from the cycle after edge T+NUM_ROUNDS. That is 11/13/15 cycles from the accept cycle to the first valid cycle.
- Throughput: one block per NUM_ROUNDS+1 cycles with Output_ready tied high.
- Output_block holds its last ciphertext in IDLE. It only changes again on the next accept.
- Round_key is sampled only in the cycle Key_idx presents its index. The engine places no constraint on Round_key in other cycles.
- Mid-operation reset: an asynchronous Rst_n assertion in any state returns everything to reset values immediately. The partial block is discarded and no Output_valid is produced.
- Input_valid/Output_ready may toggle arbitrarily. Input_block only needs to be stable in the accept cycle.

Test Plan:
- AES-128 (NUM_ROUNDS=10): bench key store expands key 000102030405060708090a0b0c0d0e0f; plaintext 00112233445566778899aabbccddeeff -> Output_block 69c4e0d86a7b0430d8cdb78070b4c55a. Output_valid rises exactly 11 cycles after the accept cycle; Key_idx sequence 0,1..10.
- AES-256 (NUM_ROUNDS=14): key 000102...1e1f, same plaintext -> 8ea2b7ca516745bfeafc49904b496089 after 15 cycles; Key_idx reaches 14.
- Backpressure: Output_ready=0 for 7 cycles after DONE -> Output_valid/Output_block held constant. Input_valid asserted meanwhile is not accepted (Input_ready=0). Releasing Output_ready with Input_valid=1 accepts the next block in the same cycle and enters ROUND.
- Back-to-back stream: 4 FIPS/random blocks with Output_ready=1 and Input_valid=1 -> one result every 11 cycles, all matching the reference model, no idle cycles.
- Reset mid-run: deassert Rst_n at round 5 -> on the same edge all outputs return to reset values, Input_ready=1. After release a fresh block produces the correct ciphertext.
- Key port discipline: bench drives random garbage on Round_key whenever Key_idx differs from the expected index -> results still correct.
